// File: rtl/color_mapper_pipe_if.sv
// Pixel/configuration/colour bundle between the state readout, the mapper and the VGA stage.
interface color_mapper_pipe_if #(
    parameter int unsigned SIGNAL_W = 17
);
    logic                in_valid;
    logic                renderAnt;
    logic                antCarrying;
    logic                renderSugar;
    logic                renderNest;
    logic [SIGNAL_W-1:0] renderSignal;
    logic                frame_start;
    logic                cfg_we;
    logic [1:0]          cfg_addr;
    logic [SIGNAL_W-1:0] cfg_data;
    logic                out_valid;
    logic [7:0]          VGA_R;
    logic [7:0]          VGA_G;
    logic [7:0]          VGA_B;

    modport master (
        output in_valid, renderAnt, antCarrying, renderSugar, renderNest, renderSignal,
        output frame_start, cfg_we, cfg_addr, cfg_data,
        input  out_valid, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input  in_valid, renderAnt, antCarrying, renderSugar, renderNest, renderSignal,
        input  frame_start, cfg_we, cfg_addr, cfg_data,
        output out_valid, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/color_mapper_pipe.sv
// Two-stage pixel colour mapper: classify + scale, then colour select into registered RGB.
// Optional carrying-ant blink driven by a frame counter, enabled by COLOR_MAPPER_BLINK_EN.
module color_mapper_pipe #(
    parameter int unsigned SIGNAL_W      = 17,
    parameter int unsigned DISP_MIN_INIT = 8,
    parameter int unsigned DISP_MAX_INIT = 512,
    parameter int unsigned SCALE_SH      = 1,
    parameter int unsigned BLINK_LOG2    = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    color_mapper_pipe_if.slave bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {CLS_ANT, CLS_SUGAR, CLS_NEST, CLS_SIG} cls_t;

    logic [SIGNAL_W-1:0] disp_min;
    logic [SIGNAL_W-1:0] disp_max;
    logic [1:0]          mode;

    logic [SIGNAL_W-1:0] sig_c;
    logic                nest_c;
    logic [SIGNAL_W-1:0] diff_c;
    logic [SIGNAL_W-1:0] shifted_c;
    logic [7:0]          scaled_c;
    cls_t                cls_c;

    logic                s1_valid;
    cls_t                s1_cls;
    logic                s1_hi;
    logic                s1_lo;
    logic [7:0]          s1_scaled;
    logic [1:0]          s1_mode;

    logic                blink_on_c;
    logic [23:0]         rgb_c;

    // Configuration registers; address 3 is reserved and drops the write.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            disp_min <= SIGNAL_W'(DISP_MIN_INIT);
            disp_max <= SIGNAL_W'(DISP_MAX_INIT);
            mode     <= 2'd0;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                2'd0:    disp_min <= bus.cfg_data;
                2'd1:    disp_max <= bus.cfg_data;
                2'd2:    mode     <= bus.cfg_data[1:0];
                default: ;
            endcase
        end
    end

    // Stage 1 combinational: scrub unknowns, classify, scale the signal.
    always_comb begin
        sig_c     = $isunknown(bus.renderSignal) ? '0 : bus.renderSignal;
        nest_c    = $isunknown(bus.renderNest) ? 1'b0 : bus.renderNest;
        diff_c    = sig_c - disp_min;
        shifted_c = diff_c >> SCALE_SH;
        scaled_c  = (shifted_c > SIGNAL_W'(255)) ? 8'hFF : shifted_c[7:0];
        cls_c     = CLS_SIG;
        if (bus.renderAnt)
            cls_c = CLS_ANT;
        else if (bus.renderSugar)
            cls_c = CLS_SUGAR;
        else if (nest_c)
            cls_c = CLS_NEST;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_valid  <= 1'b0;
            s1_cls    <= CLS_SIG;
            s1_hi     <= 1'b0;
            s1_lo     <= 1'b0;
            s1_scaled <= 8'h00;
            s1_mode   <= 2'd0;
        end else begin
            s1_valid  <= bus.in_valid;
            s1_cls    <= cls_c;
            s1_hi     <= sig_c > disp_max;
            s1_lo     <= sig_c < disp_min;
            s1_scaled <= scaled_c;
            s1_mode   <= mode;
        end
    end

`ifdef COLOR_MAPPER_BLINK_EN
    logic [CNT_W-1:0] frame_cnt;
    logic             s1_carry;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt <= '0;
            s1_carry  <= 1'b0;
        end else begin
            if (bus.frame_start)
                frame_cnt <= frame_cnt + CNT_W'(1);
            s1_carry <= bus.antCarrying;
        end
    end

    // Phase is read live so a new frame affects pixels entering stage 2 on the next edge.
    assign blink_on_c = s1_carry & frame_cnt[3'(BLINK_LOG2 - 1)];
`else
    logic unused_blink;
    assign unused_blink = ^{bus.frame_start, bus.antCarrying, CNT_W'(BLINK_LOG2)};
    assign blink_on_c   = 1'b0;
`endif

    // Stage 2 colour select; mode 3 falls through to hidden like mode 2.
    always_comb begin
        rgb_c = 24'h669900;
        case (s1_cls)
            CLS_ANT:   rgb_c = blink_on_c ? 24'hFF0000 : 24'h000000;
            CLS_SUGAR: rgb_c = 24'hFFFFFF;
            CLS_NEST:  rgb_c = 24'h8B4513;
            default: begin
                case (s1_mode)
                    2'd0: begin
                        if (s1_hi)
                            rgb_c = 24'h66FFFF;
                        else if (s1_lo)
                            rgb_c = 24'h669900;
                        else
                            rgb_c = {8'h66, 8'h99 + {2'b00, s1_scaled[7:2]}, s1_scaled};
                    end
                    2'd1:    rgb_c = s1_lo ? 24'h669900 : 24'h66FFFF;
                    default: rgb_c = 24'h669900;
                endcase
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.out_valid <= 1'b0;
            bus.VGA_R     <= 8'h00;
            bus.VGA_G     <= 8'h00;
            bus.VGA_B     <= 8'h00;
        end else begin
            bus.out_valid <= s1_valid;
            if (s1_valid)
                {bus.VGA_R, bus.VGA_G, bus.VGA_B} <= rgb_c;
        end
    end
endmodule
